// File: rtl/pc_sequencer_pkg.sv
// Shared processor constants: PC/stack defaults and the next-PC select encoding.
package pc_sequencer_pkg;

    localparam int PC_W_DEF      = 64;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_TARGET = 2'd1,
        SEL_RAS    = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a full stack overwrites its oldest entry on push,
// and push+pop together rewrite the current top in place.
module ras_stack
    import pc_sequencer_pkg::*;
#(
    parameter int W     = PC_W_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [PTR_W:0]              count_q, count_d;
    logic [DEPTH-1:0][W-1:0]     mem_q, mem_d;
    logic [PTR_W-1:0]            top_idx;
    logic                        pop_ok;

    // ptr_q is the next free slot; once full it also names the oldest entry.
    assign top_idx = ptr_q - PTR_W'(1);
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push && pop_ok) begin
            mem_d[top_idx] = push_data;
        end else if (pop_ok) begin
            ptr_d   = top_idx;
            count_d = count_q - (PTR_W+1)'(1);
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (count_q != (PTR_W+1)'(DEPTH))
                count_d = count_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign top   = mem_q[top_idx];
    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC register and next-PC select (sequential, PC-relative branch, return stack).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                         CLK,
    input  logic                         Reset_L,
    input  logic                         Stall,
    input  logic                         Branch,
    input  logic                         BranchInvert,
    input  logic                         ALUZero,
    input  logic                         Uncondbranch,
    input  logic                         Link,
    input  logic                         Return,
    input  logic [PC_W-1:0]              SignExtImm,
    output logic [PC_W-1:0]              CurrentPC,
    output logic [PC_W-1:0]              NextPC,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         RasUnderflow
);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             underflow_q, underflow_d;
    logic [PC_W-1:0]  seq_pc, target_pc, ras_top;
    logic             ras_empty, push, pop;
    pc_sel_e          sel;

    assign seq_pc    = pc_q + PC_W'(4);
    assign target_pc = pc_q + (SignExtImm << 2);
    assign ras_empty = (RasCount == '0);

    // Stack traffic is suppressed under stall and reset so neither can leak a push/pop.
    assign push = Reset_L && !Stall && Uncondbranch && Link;
    assign pop  = Reset_L && !Stall && Return && !ras_empty;

    always_comb begin
        sel = SEL_SEQ;
        if (Return && !ras_empty)
            sel = SEL_RAS;
        else if (Uncondbranch)
            sel = SEL_TARGET;
        else if (Branch && (ALUZero ^ BranchInvert))
            sel = SEL_TARGET;
    end

    always_comb begin
        pc_d        = pc_q;
        underflow_d = 1'b0;
        if (!Reset_L) begin
            pc_d = RESET_PC;
        end else if (!Stall) begin
            underflow_d = Return && ras_empty;
            case (sel)
                SEL_RAS:    pc_d = ras_top;
                SEL_TARGET: pc_d = target_pc;
                default:    pc_d = seq_pc;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            pc_q        <= RESET_PC;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            underflow_q <= underflow_d;
        end
    end

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .push      (push),
        .pop       (pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .count     (RasCount)
    );

    assign CurrentPC    = pc_q;
    assign NextPC       = pc_d;
    assign RasUnderflow = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues expected state per cycle.
module tb_pc_sequencer;

    localparam int          PC_W  = 64;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h100;

    logic            CLK = 1'b0;
    logic            Reset_L, Stall, Branch, BranchInvert, ALUZero;
    logic            Uncondbranch, Link, Return;
    logic [63:0]     SignExtImm;
    logic [63:0]     CurrentPC, NextPC;
    logic [2:0]      RasCount;
    logic            RasUnderflow;

    typedef struct {
        logic [63:0] pc;
        int          cnt;
        bit          uf;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mstk[$];
    logic [63:0] mpc;
    bit          muf;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Stall(Stall), .Branch(Branch),
        .BranchInvert(BranchInvert), .ALUZero(ALUZero), .Uncondbranch(Uncondbranch),
        .Link(Link), .Return(Return), .SignExtImm(SignExtImm),
        .CurrentPC(CurrentPC), .NextPC(NextPC), .RasCount(RasCount),
        .RasUnderflow(RasUnderflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict with the model, check NextPC before the edge and state after.
    task automatic step(input string tag, input bit rst, input bit stl, input bit br,
                        input bit inv, input bit z, input bit ub, input bit lk,
                        input bit ret, input logic [63:0] imm);
        exp_t        e, g;
        logic [63:0] seq, tgt, npc;
        bit          popok, pushv;
        Reset_L = ~rst; Stall = stl; Branch = br; BranchInvert = inv; ALUZero = z;
        Uncondbranch = ub; Link = lk; Return = ret; SignExtImm = imm;
        if (rst) begin
            mpc = RPC; mstk.delete(); muf = 1'b0;
        end else if (stl) begin
            muf = 1'b0;
        end else begin
            seq   = mpc + 64'd4;
            tgt   = mpc + (imm << 2);
            popok = ret && (mstk.size() > 0);
            pushv = ub && lk;
            if (popok)                 npc = mstk[$];
            else if (ub)               npc = tgt;
            else if (br && (z ^ inv))  npc = tgt;
            else                       npc = seq;
            muf = ret && (mstk.size() == 0);
            if (popok && pushv) mstk[$] = seq;
            else if (popok) void'(mstk.pop_back());
            else if (pushv) begin
                if (mstk.size() == DEPTH) void'(mstk.pop_front());
                mstk.push_back(seq);
            end
            mpc = npc;
        end
        e.pc = mpc; e.cnt = mstk.size(); e.uf = muf;
        sb.push_back(e);
        #1;
        chk({tag, ".npc"}, NextPC, e.pc);
        @(posedge CLK);
        #1;
        g = sb.pop_front();
        chk({tag, ".pc"},  CurrentPC, g.pc);
        chk({tag, ".cnt"}, 64'(RasCount), 64'(g.cnt));
        chk({tag, ".uf"},  64'(RasUnderflow), 64'(g.uf));
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic call(input string tag, input logic [63:0] imm);
        step(tag, 0, 0, 0, 0, 0, 1, 1, 0, imm);
    endtask

    task automatic ret_op(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 1, '0);
    endtask

    task automatic jump_to(input logic [63:0] addr);
        logic signed [63:0] d;
        d = addr - mpc;
        step("jmp", 0, 0, 0, 0, 0, 1, 0, 0, d >>> 2);
    endtask

    initial begin
        mpc = RPC; muf = 1'b0;
        // reset and sequential fetch
        step("rst0", 1, 0, 0, 0, 0, 1, 1, 1, 64'h5);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, '0);
        chk("rst.const", CurrentPC, 64'h100);
        idle("seq1"); idle("seq2"); idle("seq3");
        chk("seq.const", CurrentPC, 64'h10C);

        // conditional branches
        jump_to(64'h200);
        step("cbz", 0, 0, 1, 0, 1, 0, 0, 0, -64'sd4);
        chk("cbz.const", CurrentPC, 64'h1F0);
        jump_to(64'h200);
        step("cbnz_nt", 0, 0, 1, 1, 1, 0, 0, 0, -64'sd4);
        chk("cbnz.const", CurrentPC, 64'h204);
        step("cbz_nt", 0, 0, 1, 0, 0, 0, 0, 0, 64'h8);
        step("cbnz_t", 0, 0, 1, 1, 0, 0, 0, 0, 64'h8);
        step("link_no_ub", 0, 0, 0, 0, 0, 0, 1, 0, '0);

        // call / return
        jump_to(64'h40);
        call("bl", 64'h10);
        chk("bl.const", CurrentPC, 64'h80);
        ret_op("ret");
        chk("ret.const", CurrentPC, 64'h44);

        // overflow then underflow
        for (int i = 0; i < 5; i++) call("ovf_call", 64'h10 + 64'(i));
        for (int i = 0; i < 4; i++) ret_op("ovf_ret");
        ret_op("udf_ret");
        idle("udf_clr");

        // stall holds everything and masks underflow
        call("pre_stall", 64'h20);
        step("stall_bl", 0, 1, 0, 0, 0, 1, 1, 0, 64'h40);
        step("stall_ret", 0, 1, 0, 0, 0, 0, 0, 1, '0);
        ret_op("post_stall");
        step("stall_udf", 0, 1, 0, 0, 0, 0, 0, 1, '0);

        // wrap at top of address space
        jump_to(64'hFFFF_FFFF_FFFF_FFFC);
        idle("wrap");
        chk("wrap.const", CurrentPC, 64'h0);

        // simultaneous return + call
        jump_to(64'h4FC);
        call("mk500", 64'h100);
        jump_to(64'h60);
        step("ret_bl", 0, 0, 0, 0, 0, 1, 1, 1, 64'h30);
        chk("ret_bl.const", CurrentPC, 64'h500);
        ret_op("ret_new_top");
        chk("new_top.const", CurrentPC, 64'h64);

        // simultaneous on empty stack: target, push, underflow
        step("ret_bl_empty", 0, 0, 0, 0, 0, 1, 1, 1, 64'h8);
        idle("ret_bl_empty2");

        // reset discards an in-flight push
        call("pre_rst", 64'h4);
        step("rst_push", 1, 0, 0, 0, 0, 1, 1, 0, 64'h4);
        idle("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
